// File: rtl/mod_pkg.sv
// Shared constants and types for the modular arithmetic group.
package mod_pkg;

   localparam int DW_FIELD = 256;

   localparam logic [DW_FIELD-1:0] SM2_P =
      256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } red_state_t;

endpackage

// File: rtl/mod_red_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder and subtract the modulus once if it fits. Assumes r < m, so
// the shifted value is below 2m and one subtract brings it back under m.
module mod_red_step #(
   parameter int DW = 256
) (
   input  logic [DW-1:0] r,
   input  logic          bit_in,
   input  logic [DW-1:0] m,
   output logic [DW-1:0] r_next
);

   logic [DW:0] t;
   logic        ge;

   assign t  = {r, bit_in};
   assign ge = (t >= {1'b0, m});

   // The true difference is below m, so the low DW bits alone are exact.
   assign r_next = ge ? (t[DW-1:0] - m) : t[DW-1:0];

endmodule

// File: rtl/mod_red_512b_seq.sv
// Bit-serial reducer: r = x mod m for a 2*DW-bit x and a DW-bit m,
// one quotient bit per clock, vld/rdy/fin handshake.
module mod_red_512b_seq
   import mod_pkg::*;
#(
   parameter  int DW = DW_FIELD,
   localparam int XW = 2 * DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          red_vld_i,
   input  logic [XW-1:0] red_x_i,
   input  logic [DW-1:0] red_m_i,
   output logic          red_rdy_o,
   output logic          red_fin_o,
   output logic [DW-1:0] red_r_o,
   output logic          red_err_o
);

   localparam int CW = $clog2(XW);

   red_state_t    state_reg, state_next;
   logic [XW-1:0] x_reg;
   logic [DW-1:0] m_reg;
   logic [DW-1:0] r_reg;
   logic [DW-1:0] r_step;
   logic [CW-1:0] cnt_reg;
   logic [DW-1:0] res_reg;
   logic          err_reg;
   logic          accept;
   logic          m_zero;

   assign accept  = red_vld_i & red_rdy_o;
   assign m_zero  = (red_m_i == '0);
   assign red_r_o   = res_reg;
   assign red_err_o = err_reg;

   mod_red_step #(.DW(DW)) u_step (
      .r      (r_reg),
      .bit_in (x_reg[XW-1]),
      .m      (m_reg),
      .r_next (r_step)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake outputs; DONE accepts a new request like IDLE.
   always_comb begin
      state_next = state_reg;
      red_rdy_o  = 1'b1;
      red_fin_o  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (red_vld_i) begin
               state_next = m_zero ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            red_rdy_o = 1'b0;
            if (cnt_reg == '0) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            red_fin_o = 1'b1;
            if (red_vld_i) begin
               state_next = m_zero ? ST_DONE : ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Operand capture, per-bit reduction, and result latch on completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_reg   <= '0;
         m_reg   <= '0;
         r_reg   <= '0;
         cnt_reg <= '0;
         res_reg <= '0;
         err_reg <= 1'b0;
      end else if (accept) begin
         x_reg   <= red_x_i;
         m_reg   <= red_m_i;
         r_reg   <= '0;
         cnt_reg <= CW'(XW - 1);
         err_reg <= 1'b0;
         if (m_zero) begin
            res_reg <= '0;
            err_reg <= 1'b1;
         end
      end else if (state_reg == ST_RUN) begin
         x_reg   <= {x_reg[XW-2:0], 1'b0};
         r_reg   <= r_step;
         cnt_reg <= cnt_reg - 1'b1;
         if (cnt_reg == '0) begin
            res_reg <= r_step;
         end
      end
   end

endmodule

// File: tb/tb_mod_red_512b_seq.sv
// Directed bench for the bit-serial modular reducer.
module tb_mod_red_512b_seq;
   import mod_pkg::*;

   localparam int DW = 256;
   localparam int XW = 512;

   logic          clk;
   logic          rst_n;
   logic          red_vld_i;
   logic [XW-1:0] red_x_i;
   logic [DW-1:0] red_m_i;
   logic          red_rdy_o;
   logic          red_fin_o;
   logic [DW-1:0] red_r_o;
   logic          red_err_o;

   int n_checks = 0;
   int n_errors = 0;

   mod_red_512b_seq #(.DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .red_vld_i (red_vld_i),
      .red_x_i   (red_x_i),
      .red_m_i   (red_m_i),
      .red_rdy_o (red_rdy_o),
      .red_fin_o (red_fin_o),
      .red_r_o   (red_r_o),
      .red_err_o (red_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One request with operands released right after accept; checks latency,
   // busy length, result, error flag and the single-cycle fin pulse.
   task automatic run_red(input string tag, input logic [XW-1:0] x, input logic [DW-1:0] m,
                          input logic [DW-1:0] exp_r, input logic exp_err, input int exp_lat);
      int lat;
      int busy;
      int w;
      w = 0;
      @(negedge clk);
      while (!red_rdy_o && w < 1000) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_rdy"}, red_rdy_o, 1'b1);
      red_vld_i = 1'b1;
      red_x_i   = x;
      red_m_i   = m;
      @(posedge clk);
      #1;
      red_vld_i = 1'b0;
      red_x_i   = ~x;
      red_m_i   = ~m;
      lat  = 0;
      busy = 0;
      for (int i = 1; i <= 1000; i++) begin
         @(negedge clk);
         if (!red_rdy_o) busy++;
         if (red_fin_o) begin
            lat = i;
            break;
         end
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_busy"}, busy, exp_lat - 1);
      check({tag, "_r"}, red_r_o, exp_r);
      check({tag, "_err"}, red_err_o, exp_err);
      $display("txn %s: lat=%0d r=%0h err=%0b", tag, lat, red_r_o, red_err_o);
      @(negedge clk);
      check({tag, "_fin_pulse"}, red_fin_o, 1'b0);
      check({tag, "_r_hold"}, red_r_o, exp_r);
   endtask

   initial begin
      logic [XW-1:0] x_sm2;
      int spacing;
      int fins;

      rst_n     = 1'b0;
      red_vld_i = 1'b0;
      red_x_i   = '0;
      red_m_i   = '0;
      #1;
      check("rst_rdy", red_rdy_o, 1'b1);
      check("rst_fin", red_fin_o, 1'b0);
      check("rst_r",   red_r_o,   '0);
      check("rst_err", red_err_o, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run_red("basic",   512'd100, 256'd7, 256'd2, 1'b0, 513);
      run_red("exactmul", {XW{1'b1}}, {DW{1'b1}}, 256'd0, 1'b0, 513);
      run_red("bigmod",  (512'd1 << 511) + 512'd5, 256'd1 << 255, 256'd5, 1'b0, 513);
      x_sm2 = {256'd0, SM2_P};
      x_sm2 = x_sm2 * 3 + 512'h1234;
      run_red("sm2",     x_sm2, SM2_P, 256'h1234, 1'b0, 513);
      run_red("xltm",    512'h55, 256'h100, 256'h55, 1'b0, 513);
      run_red("mzero",   512'd12345, 256'd0, 256'd0, 1'b1, 1);
      run_red("mone",    512'd12345, 256'd1, 256'd0, 1'b0, 513);

      // Back-to-back: vld held high, garbage during RUN, second request in DONE.
      @(negedge clk);
      red_vld_i = 1'b1;
      red_x_i   = 512'd100;
      red_m_i   = 256'd7;
      @(posedge clk);
      #1;
      fins = 0;
      for (int i = 1; i <= 1000; i++) begin
         @(negedge clk);
         if (red_fin_o) begin
            fins = i;
            check("b2b_r1", red_r_o, 256'd2);
            red_x_i = 512'd1000;
            red_m_i = 256'd13;
            break;
         end
         red_x_i = {16{$urandom}};
         red_m_i = {8{$urandom}};
      end
      check("b2b_lat1", fins, 513);
      @(posedge clk);
      #1;
      red_vld_i = 1'b0;
      spacing = 0;
      for (int j = 1; j <= 1000; j++) begin
         @(negedge clk);
         if (red_fin_o) begin
            spacing = j;
            break;
         end
      end
      check("b2b_spacing", spacing, 513);
      check("b2b_r2", red_r_o, 256'd12);
      $display("txn b2b: spacing=%0d r=%0h", spacing, red_r_o);

      // Load a nonzero result, then abort the next operation mid-run.
      run_red("preload", 512'h55, 256'h100, 256'h55, 1'b0, 513);
      @(negedge clk);
      red_vld_i = 1'b1;
      red_x_i   = 512'd100;
      red_m_i   = 256'd7;
      @(posedge clk);
      #1;
      red_vld_i = 1'b0;
      repeat (200) @(negedge clk);
      check("abort_busy", red_rdy_o, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_rdy", red_rdy_o, 1'b1);
      check("abort_fin", red_fin_o, 1'b0);
      check("abort_r",   red_r_o,   '0);
      check("abort_err", red_err_o, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      fins = 0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (red_fin_o) fins++;
      end
      check("abort_nofin", fins, 0);
      $display("txn abort: fins_after_reset=%0d", fins);
      run_red("after_rst", 512'd1000, 256'd13, 256'd12, 1'b0, 513);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mod_red_512b_seq.md
Name: mod_red_512b_seq

Overview:
- Bit-serial modular reducer: computes r = x mod m for a 2*DW-bit operand and a DW-bit modulus.
- Consumes the double-width products of the SM2 multiplier datapath and returns them to field width.
- Restoring shift/conditional-subtract algorithm, one quotient bit per clock.
- Sits after the multiplier stage in the mod_mul group and reuses the vld/fin handshake style.

Parameters:
- DW, 256, modulus and result width in bits.
- XW, 2*DW, dividend width; derived, not overridden.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- red_vld_i  input  1  request strobe; accepted only when red_rdy_o=1.
- red_x_i  input  XW  dividend, sampled on accept.
- red_m_i  input  DW  modulus, sampled on accept.
- red_rdy_o  output  1  high in IDLE and DONE; low in RUN.
- red_fin_o  output  1  one-cycle completion pulse.
- red_r_o  output  DW  remainder; valid from the red_fin_o cycle until the next accept.
- red_err_o  output  1  set with red_fin_o when m==0; held with red_r_o.

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_n. Reset forces:
  - state=IDLE, red_rdy_o=1, red_fin_o=0, red_r_o=0, red_err_o=0;
  - all internal registers (x shift register, m, r, cnt) to 0.
- FSM states:
  - IDLE: red_rdy_o=1. On red_vld_i:
    - capture x and m, set r=0, cnt=XW-1, clear red_err_o;
    - if m==0 go to DONE with r=0 and err=1;
    - otherwise go to RUN.
  - RUN: red_rdy_o=0. Each cycle:
    - t = {r, x[XW-1]} (DW+1 bits);
    - if t>=m then r=t-m, else r=t[DW-1:0];
    - x shifts left by 1; cnt decrements.
    - When cnt==0 is processed, go to DONE.
  - DONE: red_fin_o=1 for exactly one cycle, red_rdy_o=1.
    - red_vld_i in DONE is accepted exactly as in IDLE (back-to-back allowed).
    - With no request, go to IDLE.
- Invariant: r<m holds at all times in RUN, so t<2m fits in DW+1 bits and a single subtract suffices. Compare and subtract are unsigned and DW+1 bits wide.
- Latency:
  - Accept edge to red_fin_o high is XW+1 clocks (513 for DW=256).
  - For the m==0 path it is 1 clock.
  - Throughput is one reduction per XW+1 clocks.
- Boundaries:
  - red_vld_i while in RUN is ignored: no capture and no effect on the operation in flight.
  - red_x_i and red_m_i may change freely after accept.
  - red_r_o and red_err_o update only on the DONE transition and are otherwise stable.
  - m==1 yields r=0 and err=0.
  - x<m yields r=x.
  - Reset asserted mid-RUN aborts immediately. No fin is issued, and the outputs show reset values.

Decomposition:
- Shared package mod_pkg:
  - DW_FIELD=256;
  - SM2_P = FFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE.
- One sub-module: mod_red_step, a combinational conditional subtractor.
  - Inputs: r[DW-1:0], bit_in, m[DW-1:0]. Output: r_next[DW-1:0].
  - It is reused later by a radix-4 variant.

Test Plan:
- Basic case: x=100, m=7, vld for 1 cycle.
  - red_fin_o pulses exactly 513 clocks after accept, with red_r_o=2 and red_err_o=0.
  - red_rdy_o is low for 512 cycles.
- Exact multiple: x=2^512-1, m=2^256-1 → red_r_o=0.
- Large modulus: x=2^511+5, m=2^255 → red_r_o=5.
- SM2 field case: x=SM2_P*3+0x1234, m=SM2_P → red_r_o=0x1234.
- Corner cases:
  - x=0x55, m=0x100 → r=0x55 (x<m).
  - m=1 → r=0.
  - m=0 → fin 1 clock after accept, r=0, err=1.
- Handshake and reset:
  - Hold red_vld_i high with changing data through RUN: only the first request is processed, and the second is accepted in the DONE cycle (back-to-back fin spacing = 513).
  - Assert rst_n low at cycle 200 of RUN: outputs go to 0 immediately, no fin follows, and the next request completes correctly.
